// File: rtl/seg_bus_decoder.sv
// seg_bus_decoder: reads back a scanned 8-digit active-low 7-segment bus into hex digits; SEG_DECODE_DP_EN adds dp_out
module seg_bus_decoder #(
  parameter int STABLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_en,
  input  logic        led_ca,
  input  logic        led_cb,
  input  logic        led_cc,
  input  logic        led_cd,
  input  logic        led_ce,
  input  logic        led_cf,
  input  logic        led_cg,
  input  logic        led_dp,
  output logic [31:0] digits,
  output logic [7:0]  dig_valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        en_err,
  output logic [7:0]  err_cnt
`ifdef SEG_DECODE_DP_EN
  ,
  output logic [7:0]  dp_out
`endif
);
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYC - 1);
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };
`ifdef SEG_DECODE_DP_EN
  localparam int W = 16;
  logic [W-1:0] pin_w;
  assign pin_w = {led_en, led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
  logic [7:0] dp_q, dp_d;
  assign dp_out = dp_q;
`else
  localparam int W = 15;
  logic [W-1:0] pin_w;
  logic unused_dp;
  assign pin_w = {led_en, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
  assign unused_dp = led_dp;
`endif
  logic [W-1:0] s1_q, s2_q, prev_q;
  logic [7:0]   cnt_q, cnt_d;
  logic         armed_q, armed_d;
  logic [31:0]  digits_q, digits_d;
  logic [7:0]   valid_q, valid_d, seen_q, seen_d, err_cnt_q, err_cnt_d;
  logic         frame_q, frame_d, seg_err_q, seg_err_d, en_err_q, en_err_d;
  logic [7:0]   en;
  logic [6:0]   seg;
  logic         cap, one, multi, hit;
  logic [3:0]   val;

  // decode always looks at prev_q, which holds the word that has been stable for the whole window
  assign en    = prev_q[W-1 -: 8];
  assign seg   = prev_q[6:0];
  assign cap   = armed_q && cnt_q == CAP_AT;
  assign one   = $onehot(~en);
  assign multi = !one && en != 8'hFF;

  always_comb begin
    cnt_d   = (s2_q != prev_q) ? '0 : cnt_q + 8'(cnt_q != 8'hFF);
    armed_d = (s2_q != prev_q) || (armed_q && !cap);
  end

  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int k = 0; k < 16; k++)
      if (seg == SEG_TBL[k]) begin
        hit = 1'b1;
        val = 4'(k);
      end
  end

  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
`ifdef SEG_DECODE_DP_EN
    dp_d      = dp_q;
`endif
    seg_err_d = cap && one && !hit;
    en_err_d  = cap && multi;
    for (int i = 0; i < 8; i++)
      if (cap && one && !en[i]) begin
        seen_d[i]  = 1'b1;
        valid_d[i] = hit;
        if (hit) digits_d[4*i +: 4] = val;
`ifdef SEG_DECODE_DP_EN
        if (hit) dp_d[i] = ~prev_q[7];
`endif
      end
    frame_d   = cap && one && seen_d == 8'hFF;
    seen_d    = frame_d ? '0 : seen_d;
    err_cnt_d = err_cnt_q + 8'((seg_err_d || en_err_d) && err_cnt_q != 8'hFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '1;
      s2_q      <= '1;
      prev_q    <= '1;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      digits_q  <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      seg_err_q <= 1'b0;
      en_err_q  <= 1'b0;
      err_cnt_q <= '0;
`ifdef SEG_DECODE_DP_EN
      dp_q      <= '0;
`endif
    end else begin
      s1_q      <= pin_w;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      seg_err_q <= seg_err_d;
      en_err_q  <= en_err_d;
      err_cnt_q <= err_cnt_d;
`ifdef SEG_DECODE_DP_EN
      dp_q      <= dp_d;
`endif
    end
  end

  assign digits     = digits_q;
  assign dig_valid  = valid_q;
  assign frame_done = frame_q;
  assign seg_err    = seg_err_q;
  assign en_err     = en_err_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_seg_bus_decoder.sv
// tb_seg_bus_decoder: random and directed bus windows checked against a window-level model of the decoder
module tb_seg_bus_decoder;
  localparam int STABLE = 16;
  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [15:0] BLANK = 16'hFFFF;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  led_en = 8'hFF;
  logic        led_ca = 1, led_cb = 1, led_cc = 1, led_cd = 1, led_ce = 1, led_cf = 1, led_cg = 1, led_dp = 1;
  logic [31:0] digits;
  logic [7:0]  dig_valid, err_cnt;
  logic        frame_done, seg_err, en_err;
`ifdef SEG_DECODE_DP_EN
  logic [7:0]  dp_out;
`endif

  int n_chk = 0, n_fail = 0;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_valid, m_seen, m_dp, m_err;
  logic [15:0] last_key;
  int e_seg, e_en, e_fr, c_seg, c_en, c_fr;

  always #5 clk = ~clk;

  seg_bus_decoder #(.STABLE_CYC(STABLE)) dut (
    .clk(clk), .rst(rst), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp),
    .digits(digits), .dig_valid(dig_valid), .frame_done(frame_done),
    .seg_err(seg_err), .en_err(en_err), .err_cnt(err_cnt)
`ifdef SEG_DECODE_DP_EN
    , .dp_out(dp_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word layout used by the bench: {en[7:0], dp, g f e d c b a}
  function automatic logic [15:0] key(input logic [15:0] w);
`ifdef SEG_DECODE_DP_EN
    return w;
`else
    return {w[15:8], 1'b0, w[6:0]};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = '0;
    m_valid = '0; m_seen = '0; m_dp = '0; m_err = '0;
    last_key = key(BLANK);
  endtask

  // A window of n cycles is captured once iff it lasts at least STABLE cycles and differs from the previous one
  task automatic model_step(input logic [15:0] w, input int n);
    logic [7:0] en;
    int lows, idx, v;
    e_seg = 0; e_en = 0; e_fr = 0;
    en = w[15:8];
    idx = 0;
    v = -1;
    if (n >= STABLE && key(w) != last_key) begin
      lows = $countones(~en);
      if (lows == 1) begin
        for (int i = 0; i < 8; i++) if (!en[i]) idx = i;
        for (int k = 0; k < 16; k++) if (w[6:0] == TBL[k]) v = k;
        m_seen[idx] = 1'b1;
        if (v >= 0) begin
          m_dig[idx] = 4'(v);
          m_valid[idx] = 1'b1;
          m_dp[idx] = ~w[7];
        end else begin
          m_valid[idx] = 1'b0;
          e_seg = 1;
        end
        if (m_seen == 8'hFF) begin
          e_fr = 1;
          m_seen = '0;
        end
      end else if (lows > 1) e_en = 1;
      if (e_seg + e_en > 0 && m_err != 8'hFF) m_err++;
    end
    last_key = key(w);
  endtask

  task automatic drive(input logic [15:0] w);
    led_en = w[15:8]; led_dp = w[7];
    {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = w[6:0];
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      c_seg += int'(seg_err); c_en += int'(en_err); c_fr += int'(frame_done);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] ed;
    for (int i = 0; i < 8; i++) ed[4*i +: 4] = m_dig[i];
    check({tag, "_digits"}, digits, ed);
    check({tag, "_valid"}, dig_valid, m_valid);
    check({tag, "_err_cnt"}, err_cnt, m_err);
    check({tag, "_seg_err_pulses"}, c_seg, e_seg);
    check({tag, "_en_err_pulses"}, c_en, e_en);
    check({tag, "_frame_pulses"}, c_fr, e_fr);
`ifdef SEG_DECODE_DP_EN
    check({tag, "_dp_out"}, dp_out, m_dp);
`endif
  endtask

  task automatic window(input logic [15:0] w, input int n, input string tag);
    c_seg = 0; c_en = 0; c_fr = 0;
    drive(w);
    run(n);
    model_step(w, n);
    compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, digits, 0);
    check({tag, "_valid"}, dig_valid, 0);
    check({tag, "_pulses"}, {frame_done, seg_err, en_err}, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    logic [15:0] w, w7;
    logic [7:0] en;
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_init");
    rst = 1'b0;
    window(BLANK, 30, "idle");
    w7 = {8'hF7, 1'b1, TBL[7]};
    window(w7, 10, "glitch");
    window(BLANK, 30, "glitch_blank");
    c_seg = 0; c_en = 0; c_fr = 0;
    drive(w7);
    run(STABLE + 2);
    check("lat_before", {dig_valid[3], digits[15:12]}, 5'h00);
    run(1);
    check("lat_at", {dig_valid[3], digits[15:12]}, 5'h17);
    run(1);
    model_step(w7, STABLE + 4);
    compare_all("capture");
    for (int d = 0; d < 8; d++) begin
      en = ~(8'b1 << d);
      window({en, 1'b1, TBL[d]}, 20, "frame");
    end
    check("frame_last_pulse", c_fr, 1);
    check("frame_digits", digits, 32'h76543210);
    check("frame_valid", dig_valid, 8'hFF);
    window({8'hFE, 1'b1, 7'h7F}, 20, "seg_bad");
    check("seg_bad_valid0", dig_valid[0], 0);
    check("seg_bad_cnt", err_cnt, 1);
    window({8'hFC, 1'b1, TBL[0]}, 20, "en_bad");
    check("en_bad_cnt", err_cnt, 2);
    check("en_bad_digits", digits, 32'h76543210);
    for (int i = 0; i < 300; i++)
      window((i % 2 == 0) ? {8'hFE, 1'b1, 7'h7F} : {8'hFC, 1'b1, TBL[0]}, 20, "err_sat");
    check("err_sat_cnt", err_cnt, 8'hFF);
`ifdef SEG_DECODE_DP_EN
    window({8'hDF, 1'b0, TBL[10]}, 20, "dp");
    check("dp_bit5", dp_out[5], 1);
    check("dp_digit5", digits[23:20], 4'hA);
`endif
    for (int r = 0; r < 250; r++) begin
      do begin
        case ($urandom_range(0, 9))
          0: en = 8'hFF;
          1: do en = 8'($urandom); while ($countones(~en) < 2);
          default: en = ~(8'b1 << $urandom_range(0, 7));
        endcase
        w = {en, 1'($urandom), ($urandom_range(0, 4) == 0) ? 7'($urandom) : TBL[$urandom_range(0, 15)]};
      end while (key(w) == last_key);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, STABLE - 1) : $urandom_range(STABLE + 4, STABLE + 10);
      window(w, n, "rand");
    end
    drive({8'hFB, 1'b0, TBL[9]});
    run(10);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    drive(BLANK);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    window(BLANK, 40, "rst_release");
    check_zero("rst_release");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
